// File: rtl/dram_cpu_slot.sv
// dram_cpu_slot: DRAM-side responder that owns the 4-clock DRAM cycle, arbitrates video vs CPU and routes read data by tag
// Ports: clk/rst_n (sync, active low); c0..c3 phase strobes; cpu_req/cpu_rnw/cpu_addr/cpu_wrbsel/cpu_wrdata in,
// cpu_next/cpu_strobe/cpu_latch/cpu_rddata out; vid_req/vid_addr in, vid_strobe out; dram_req/dram_rnw/dram_addr/
// dram_wrdata/dram_bsel command out; dram_rdvalid/dram_rddata in; rd_err sticky unexpected-read flag.
module dram_cpu_slot #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        c0,
    output logic        c1,
    output logic        c2,
    output logic        c3,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [20:0] cpu_addr,
    input  logic        cpu_wrbsel,
    input  logic [7:0]  cpu_wrdata,
    output logic        cpu_next,
    output logic        cpu_strobe,
    output logic        cpu_latch,
    output logic [15:0] cpu_rddata,
    input  logic        vid_req,
    input  logic [20:0] vid_addr,
    output logic        vid_strobe,
    output logic        dram_req,
    output logic        dram_rnw,
    output logic [20:0] dram_addr,
    output logic [15:0] dram_wrdata,
    output logic [1:0]  dram_bsel,
    input  logic        dram_rdvalid,
    input  logic [15:0] dram_rddata,
    output logic        rd_err
);
    typedef enum logic [1:0] {IDLE, CPU, VID} owner_t;
    logic [1:0]        phase;
    owner_t            owner;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_cpu;
    logic              push;
    logic              hit_cpu;
    assign c0 = rst_n && phase == 2'd0;
    assign c1 = rst_n && phase == 2'd1;
    assign c2 = rst_n && phase == 2'd2;
    assign c3 = rst_n && phase == 2'd3;
    assign cpu_next = !vid_req;
    // dram_req is only ever high during c0, so this pushes one tag per read command
    assign push = dram_req && dram_rnw;
    // the oldest tag slot lines up with the clock that dram_rdvalid is due
    assign hit_cpu = dram_rdvalid && tag_v[RD_LAT-1] && tag_cpu[RD_LAT-1];
    assign vid_strobe = rst_n && dram_rdvalid && tag_v[RD_LAT-1] && !tag_cpu[RD_LAT-1];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase       <= 2'd0;
            owner       <= IDLE;
            tag_v       <= '0;
            tag_cpu     <= '0;
            dram_req    <= 1'b0;
            dram_rnw    <= 1'b1;
            dram_addr   <= '0;
            dram_wrdata <= '0;
            dram_bsel   <= 2'b11;
            cpu_strobe  <= 1'b0;
            cpu_latch   <= 1'b0;
            cpu_rddata  <= '0;
            rd_err      <= 1'b0;
        end else begin
            phase    <= phase + 2'd1;
            dram_req <= c3 && (vid_req || cpu_req);
            if (c3) begin
                owner <= vid_req ? VID : cpu_req ? CPU : IDLE;
                if (vid_req) begin
                    dram_rnw  <= 1'b1;
                    dram_addr <= vid_addr;
                    dram_bsel <= 2'b11;
                end else if (cpu_req) begin
                    dram_rnw    <= cpu_rnw;
                    dram_addr   <= cpu_addr;
                    dram_wrdata <= {cpu_wrdata, cpu_wrdata};
                    dram_bsel   <= cpu_rnw ? 2'b11 : cpu_wrbsel ? 2'b10 : 2'b01;
                end
            end
            tag_v   <= (tag_v << 1) | RD_LAT'(push);
            tag_cpu <= (tag_cpu << 1) | RD_LAT'(push && owner == CPU);
            cpu_strobe <= hit_cpu;
            if (hit_cpu)
                cpu_rddata <= dram_rddata;
            // a fresh strobe beats the c3 clear
            cpu_latch <= hit_cpu || (cpu_latch && !c3);
            if (dram_rdvalid && !tag_v[RD_LAT-1])
                rd_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dram_cpu_slot.sv
// tb_dram_cpu_slot: self-checking bench for dram_cpu_slot with directed and randomized DRAM cycles
module tb_dram_cpu_slot;
    localparam int RD_LAT = 2;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        c0, c1, c2, c3;
    logic        cpu_req, cpu_rnw, cpu_wrbsel;
    logic [20:0] cpu_addr, vid_addr;
    logic [7:0]  cpu_wrdata;
    logic        cpu_next, cpu_strobe, cpu_latch;
    logic [15:0] cpu_rddata;
    logic        vid_req, vid_strobe;
    logic        dram_req, dram_rnw;
    logic [20:0] dram_addr;
    logic [15:0] dram_wrdata;
    logic [1:0]  dram_bsel;
    logic        dram_rdvalid;
    logic [15:0] dram_rddata;
    logic        rd_err;
    int checks = 0;
    int errors = 0;
    int ph = 0;
    logic [20:0] m_addr;
    logic        m_rnw;
    logic [1:0]  m_bsel;
    logic [15:0] m_rd;
    logic        m_err;

    dram_cpu_slot #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wrbsel(cpu_wrbsel),
        .cpu_wrdata(cpu_wrdata), .cpu_next(cpu_next), .cpu_strobe(cpu_strobe), .cpu_latch(cpu_latch),
        .cpu_rddata(cpu_rddata), .vid_req(vid_req), .vid_addr(vid_addr), .vid_strobe(vid_strobe),
        .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr), .dram_wrdata(dram_wrdata),
        .dram_bsel(dram_bsel), .dram_rdvalid(dram_rdvalid), .dram_rddata(dram_rddata), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        ph = (ph + 1) % 4;
        chk("phase", {c0, c1, c2, c3}, rst_n ? (4'b1000 >> ph) : 4'b0000);
    endtask

    // one full DRAM cycle: entered and left in c3; owner decided by the spec priority rule
    task automatic slot(input bit vr, input bit cr, input bit rnw, input logic [20:0] ca,
                        input logic [20:0] va, input bit bs, input logic [7:0] wd, input logic [15:0] data);
        int  own;
        bit  is_rd;
        own = vr ? 2 : cr ? 1 : 0;
        is_rd = own == 2 || (own == 1 && rnw);
        vid_req = vr; cpu_req = cr; cpu_rnw = rnw; cpu_addr = ca; vid_addr = va;
        cpu_wrbsel = bs; cpu_wrdata = wd;
        #1;
        chk("cpu_next", cpu_next, !vr);
        if (own != 0) begin
            m_addr = vr ? va : ca;
            m_rnw  = vr ? 1'b1 : rnw;
            m_bsel = (vr || rnw) ? 2'b11 : bs ? 2'b10 : 2'b01;
        end
        tick;
        vid_req = 0; cpu_req = 0; cpu_addr = 21'($urandom); vid_addr = 21'($urandom);
        cpu_wrdata = 8'($urandom); cpu_rnw = 1'($urandom);
        chk("dram_req_c0", dram_req, own != 0);
        chk("latch_clr", cpu_latch, 0);
        chk("dram_addr", dram_addr, m_addr);
        chk("dram_rnw", dram_rnw, m_rnw);
        chk("dram_bsel", dram_bsel, m_bsel);
        if (own == 1 && !rnw) chk("dram_wrdata", dram_wrdata, {wd, wd});
        for (int k = 1; k < 4; k++) begin
            tick;
            dram_rdvalid = 0;
            chk("dram_req_idle", dram_req, 0);
            chk("cpu_strobe", cpu_strobe, own == 1 && is_rd && k == RD_LAT + 1);
            if (own == 1 && is_rd && k == RD_LAT + 1) begin
                m_rd = data;
                chk("latch_set", cpu_latch, 1);
            end
            chk("cpu_rddata", cpu_rddata, m_rd);
            if (is_rd && k == RD_LAT) begin
                dram_rdvalid = 1; dram_rddata = data;
            end
            #1;
            chk("vid_strobe", vid_strobe, own == 2 && is_rd && k == RD_LAT);
        end
        chk("latch_c3", cpu_latch, own == 1 && is_rd);
        chk("rd_err", rd_err, m_err);
    endtask

    initial begin
        rst_n = 0; cpu_req = 0; cpu_rnw = 1; cpu_addr = 0; cpu_wrbsel = 0; cpu_wrdata = 0;
        vid_req = 0; vid_addr = 0; dram_rdvalid = 0; dram_rddata = 0;
        m_addr = 0; m_rnw = 1; m_bsel = 2'b11; m_rd = 0; m_err = 0;
        repeat (3) tick;
        chk("rst_outs", {dram_req, dram_rnw, dram_addr, dram_bsel, cpu_strobe, cpu_latch, vid_strobe, rd_err},
            {1'b0, 1'b1, 21'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("rst_wrdata", dram_wrdata, 0);
        chk("rst_rddata", cpu_rddata, 0);
        rst_n = 1; ph = 0;
        #1;
        chk("first_c0", {c0, c1, c2, c3}, 4'b1000);
        for (int i = 0; i < 15; i++) begin
            tick;
            chk("idle_req", dram_req, 0);
            chk("idle_addr", dram_addr, 0);
            chk("idle_rderr", rd_err, 0);
        end
        slot(0, 1, 1, 21'h01234, 21'h0, 0, 8'h00, 16'hBEEF);
        slot(0, 1, 0, 21'h00777, 21'h0, 1, 8'h5A, 16'h0000);
        slot(0, 1, 0, 21'h00778, 21'h0, 0, 8'hC3, 16'h0000);
        slot(1, 1, 1, 21'h0AAAA, 21'h15555, 0, 8'h00, 16'h1357);
        slot(0, 1, 1, 21'h0AAAA, 21'h0, 0, 8'h00, 16'h2468);
        slot(0, 1, 1, 21'h0BBBB, 21'h0, 0, 8'h00, 16'h9ABC);
        slot(0, 0, 1, 21'h1FFFF, 21'h1EEEE, 0, 8'h00, 16'h0000);
        for (int i = 0; i < 40; i++)
            slot($urandom_range(2) == 0, 1'($urandom), 1'($urandom), 21'($urandom), 21'($urandom),
                 1'($urandom), 8'($urandom), 16'($urandom));
        vid_req = 0; cpu_req = 0;
        dram_rdvalid = 1; dram_rddata = 16'hDEAD;
        #1;
        chk("spur_vstrobe", vid_strobe, 0);
        tick;
        dram_rdvalid = 0; m_err = 1;
        chk("spur_err", rd_err, 1);
        chk("spur_cstrobe", cpu_strobe, 0);
        chk("spur_rddata", cpu_rddata, m_rd);
        repeat (3) begin
            tick;
            chk("err_sticky", rd_err, 1);
        end
        slot(0, 1, 1, 21'h00042, 21'h0, 0, 8'h00, 16'h4242);
        cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h00099;
        tick;
        cpu_req = 0;
        chk("pre_rst_req", dram_req, 1);
        rst_n = 0;
        tick;
        chk("rst_strobe", cpu_strobe, 0);
        chk("rst_err", rd_err, 0);
        tick;
        rst_n = 1; ph = 0;
        m_addr = 0; m_rnw = 1; m_bsel = 2'b11; m_rd = 0; m_err = 0;
        #1;
        chk("restart_c0", {c0, c1, c2, c3}, 4'b1000);
        dram_rdvalid = 1; dram_rddata = 16'h7777;
        #1;
        chk("late_vstrobe", vid_strobe, 0);
        tick;
        dram_rdvalid = 0; m_err = 1;
        chk("late_err", rd_err, 1);
        chk("late_cstrobe", cpu_strobe, 0);
        chk("late_rddata", cpu_rddata, 0);
        tick;
        tick;
        slot(0, 1, 1, 21'h00100, 21'h0, 0, 8'h00, 16'hCAFE);
        slot(1, 0, 1, 21'h0, 21'h00200, 0, 8'h00, 16'hF00D);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
